full_adder_checker: RTL and testbench

FULL_ADDER_CHECKER -- requirements
Module: full_adder_checker

---
 rtl/full_adder_checker.sv | 115 +++++++++++
 tb/tb_full_adder_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_checker.sv
// Exhaustive 8-vector tester for an external full adder: drives {a,b,cin}, waits, checks, counts.
// Optional feature: FA_CHECK_STOP_ON_ERR_EN stops the pass at the first mismatching vector.
module full_adder_checker #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_sum,
    input  logic       dut_cout,
    output logic       a,
    output logic       b,
    output logic       cin,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] err_q, err_d;
    logic       exp_sum, exp_cout, mismatch;

    // Operands come straight from the vector register, so they are registered by construction.
    assign a         = vec_q[2];
    assign b         = vec_q[1];
    assign cin       = vec_q[0];
    assign vec_idx   = vec_q;
    assign err_count = err_q;
    assign busy      = (state_q == APPLY) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_q == 4'd0);

    always_comb begin
        exp_sum  = a ^ b ^ cin;
        exp_cout = (a & b) | (a & cin) | (b & cin);
        mismatch = (dut_sum != exp_sum) || (dut_cout != exp_cout);
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = APPLY;
                    vec_d   = 3'd0;
                    hold_d  = 4'd0;
                    err_d   = 4'd0;
                end
            end
            APPLY: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch && (err_q != 4'd15)) begin
                    err_d = err_q + 4'd1;
                end
`ifdef FA_CHECK_STOP_ON_ERR_EN
                if (mismatch || (vec_q == 3'd7)) begin
                    state_d = DONE;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + 3'd1;
                    hold_d  = 4'd0;
                end
`else
                if (vec_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + 3'd1;
                    hold_d  = 4'd0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            hold_q  <= 4'd0;
            err_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_full_adder_checker.sv
// Bench for full_adder_checker: behavioural full adder with injectable faults, table of passes,
// plus held-start and mid-pass reset sequences.
module tb_full_adder_checker;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dut_sum, dut_cout;
    logic       a, b, cin, busy, done, pass;
    logic [2:0] vec_idx;
    logic [3:0] err_count;
    int         fault = 0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int fault;
        int exp_err;
        int first_fail;
    } vec_t;

    typedef struct {
        int err;
        int pas;
        int vec;
        int lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[4];

    full_adder_checker #(.HOLD_CYCLES(H)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dut_sum  (dut_sum),
        .dut_cout (dut_cout),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .vec_idx  (vec_idx),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Adder under test: 0 good, 1 cout stuck 0, 2 sum inverted, 3 sum stuck 1
    always_comb begin
        dut_sum  = a ^ b ^ cin;
        dut_cout = (a & b) | (a & cin) | (b & cin);
        case (fault)
            1: dut_cout = 1'b0;
            2: dut_sum  = ~(a ^ b ^ cin);
            3: dut_sum  = 1'b1;
            default: ;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input int exp_err, input int first_fail);
        exp_t e;
`ifdef FA_CHECK_STOP_ON_ERR_EN
        e.err = (exp_err > 0) ? 1 : 0;
        e.vec = first_fail;
        e.lat = (first_fail + 1) * (H + 1);
`else
        e.err = exp_err;
        e.vec = 7;
        e.lat = 8 * (H + 1);
`endif
        e.pas = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_a"}, int'(a), 0);
        chk({tag, "_b"}, int'(b), 0);
        chk({tag, "_cin"}, int'(cin), 0);
        chk({tag, "_vec"}, int'(vec_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(err_count), 0);
    endtask

    // Pulses (or raises) start, then waits for done and scores the pass against the queue head.
    task automatic run_pass(input bit hold_start);
        int   cycles;
        exp_t e;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("vec_after_start", int'(vec_idx), 0);
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            chk("abc_eq_vec", int'({a, b, cin}), int'(vec_idx));
            if (done) break;
        end
        if (!done) begin
            failures++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", cycles);
        end
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("done_latency", cycles, e.lat);
            chk("err_count", int'(err_count), e.err);
            chk("pass", int'(pass), e.pas);
            chk("vec_at_done", int'(vec_idx), e.vec);
            chk("busy_at_done", int'(busy), 0);
        end
    endtask

    initial begin
        int  waited;
        bit  seen_done;
        exp_t e;

        tbl[0] = '{fault: 0, exp_err: 0, first_fail: 7};
        tbl[1] = '{fault: 1, exp_err: 4, first_fail: 3};
        tbl[2] = '{fault: 2, exp_err: 8, first_fail: 0};
        tbl[3] = '{fault: 3, exp_err: 4, first_fail: 0};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            fault = tbl[i].fault;
            sb.push_back(make_exp(tbl[i].exp_err, tbl[i].first_fail));
            run_pass(1'b0);
            e = make_exp(tbl[i].exp_err, tbl[i].first_fail);
            repeat (3) @(posedge clk);
            #1;
            chk("done_hold", int'(done), 1);
            chk("vec_hold", int'(vec_idx), e.vec);
            chk("err_hold", int'(err_count), e.err);
        end

        // start held high across a whole pass, then restart straight out of DONE
        fault = 1;
        sb.push_back(make_exp(4, 3));
        run_pass(1'b1);
        @(posedge clk);
        #1;
        chk("restart_busy", int'(busy), 1);
        chk("restart_done", int'(done), 0);
        chk("restart_err", int'(err_count), 0);
        chk("restart_vec", int'(vec_idx), 0);
        start = 1'b0;

        // reset while vector 5 is applied aborts the pass
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        fault = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waited = 0;
        while ((vec_idx != 3'd5) && (waited < 100)) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("reached_vec5", int'(vec_idx), 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle("midreset");
        seen_done = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done || pass || busy) seen_done = 1'b1;
        end
        chk("no_done_after_abort", int'(seen_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
